// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: folds one FRAME_SIZE-bit beat per cycle into a run-time programmable CRC.
// Optional final XOR stage enabled by defining CRC_FINAL_XOR_EN (adds crc_xorout_in).
module crc_stream_engine #(
  parameter int CRC_SIZE   = 32,
  parameter int FRAME_SIZE = 8,
  parameter int CNT_W      = 16,
  parameter int SZ_W       = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  crc_poly_wr,
  input  logic [CRC_SIZE-1:0]   crc_poly_in,
  input  logic [SZ_W-1:0]       crc_poly_size_in,
  input  logic [CRC_SIZE-1:0]   crc_init_in,
`ifdef CRC_FINAL_XOR_EN
  input  logic [CRC_SIZE-1:0]   crc_xorout_in,
`endif
  input  logic                  start,
  input  logic                  data_valid,
  input  logic [FRAME_SIZE-1:0] data_in,
  input  logic                  data_last,
  output logic                  data_ready,
  output logic                  busy,
  output logic                  crc_valid,
  output logic [CRC_SIZE-1:0]   crc_out,
  output logic [CNT_W-1:0]      beat_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  logic [CRC_SIZE-1:0] poly_r;
  logic [SZ_W-1:0]     size_r;
  logic [CRC_SIZE-1:0] init_r;
  logic [CRC_SIZE-1:0] crc_r;
  logic [CRC_SIZE-1:0] crc_out_r;
  logic                crc_valid_r;
  logic                busy_r;
  logic [CNT_W-1:0]    beat_cnt_r;
`ifdef CRC_FINAL_XOR_EN
  logic [CRC_SIZE-1:0] xorout_r;
`endif

  logic                cfg_open_s;
  logic                wr_s;
  logic                start_s;
  logic                accept_s;
  logic [SZ_W-1:0]     size_clamp_s;
  logic [SZ_W-1:0]     eff_size_s;
  logic [CRC_SIZE-1:0] eff_init_s;
  logic [CRC_SIZE-1:0] mask_run_s;
  logic [CRC_SIZE-1:0] mask_new_s;
  logic [CRC_SIZE-1:0] crc_next_s;
  logic [CRC_SIZE-1:0] final_s;

  function automatic logic [CRC_SIZE-1:0] mask_f(input logic [SZ_W-1:0] n);
    logic [CRC_SIZE-1:0] m;
    for (int i = 0; i < CRC_SIZE; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

  // MSB-first bit-serial fold of one beat; top marks bit N-1 so no variable index is needed
  function automatic logic [CRC_SIZE-1:0] crc_step_f(
    input logic [CRC_SIZE-1:0]   c,
    input logic [FRAME_SIZE-1:0] d,
    input logic [CRC_SIZE-1:0]   p,
    input logic [CRC_SIZE-1:0]   m
  );
    logic [CRC_SIZE-1:0] r;
    logic [CRC_SIZE-1:0] top;
    logic                fb;
    top = m & ~(m >> 1);
    r   = c;
    for (int b = FRAME_SIZE - 1; b >= 0; b--) begin
      fb = (|(r & top)) ^ d[b];
      r  = ((r << 1) & m) ^ (fb ? p : {CRC_SIZE{1'b0}});
    end
    return r;
  endfunction

  // Handshake qualification, same-edge config bypass and the combinational beat fold
  always_comb begin
    cfg_open_s = (state_r != RUN);
    wr_s       = crc_poly_wr && cfg_open_s;
    start_s    = start && cfg_open_s;
    accept_s   = data_valid && busy_r;
    if ((crc_poly_size_in == {SZ_W{1'b0}}) || (crc_poly_size_in > SZ_W'(CRC_SIZE))) begin
      size_clamp_s = SZ_W'(CRC_SIZE);
    end else begin
      size_clamp_s = crc_poly_size_in;
    end
    if (wr_s) begin
      eff_size_s = size_clamp_s;
      eff_init_s = crc_init_in;
    end else begin
      eff_size_s = size_r;
      eff_init_s = init_r;
    end
    mask_run_s = mask_f(size_r);
    mask_new_s = mask_f(eff_size_s);
    crc_next_s = crc_step_f(crc_r, data_in, poly_r & mask_run_s, mask_run_s);
`ifdef CRC_FINAL_XOR_EN
    final_s    = (crc_next_s ^ xorout_r) & mask_run_s;
`else
    final_s    = crc_next_s & mask_run_s;
`endif
  end

  // Configuration registers, writable only outside RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poly_r   <= {CRC_SIZE{1'b0}};
      size_r   <= SZ_W'(CRC_SIZE);
      init_r   <= {CRC_SIZE{1'b0}};
`ifdef CRC_FINAL_XOR_EN
      xorout_r <= {CRC_SIZE{1'b0}};
`endif
    end else if (wr_s) begin
      poly_r   <= crc_poly_in;
      size_r   <= size_clamp_s;
      init_r   <= crc_init_in;
`ifdef CRC_FINAL_XOR_EN
      xorout_r <= crc_xorout_in;
`endif
    end
  end

  // Message FSM with running CRC, beat counter and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      crc_r       <= {CRC_SIZE{1'b0}};
      crc_out_r   <= {CRC_SIZE{1'b0}};
      crc_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      beat_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      crc_valid_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (start_s) begin
            state_r    <= RUN;
            busy_r     <= 1'b1;
            crc_r      <= eff_init_s & mask_new_s;
            beat_cnt_r <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          if (accept_s) begin
            crc_r <= crc_next_s;
            if (beat_cnt_r != {CNT_W{1'b1}}) begin
              beat_cnt_r <= beat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (data_last) begin
              state_r     <= DONE;
              busy_r      <= 1'b0;
              crc_out_r   <= final_s;
              crc_valid_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign data_ready = busy_r;
  assign busy       = busy_r;
  assign crc_valid  = crc_valid_r;
  assign crc_out    = crc_out_r;
  assign beat_cnt   = beat_cnt_r;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench for crc_stream_engine: directed catalogue CRCs plus random messages
// checked against a polynomial long-division reference model.
module tb_crc_stream_engine;

  localparam int CRC_SIZE   = 32;
  localparam int FRAME_SIZE = 8;
  localparam int CNT_W      = 16;
  localparam int SZ_W       = 6;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  crc_poly_wr = 1'b0;
  logic [CRC_SIZE-1:0]   crc_poly_in = '0;
  logic [SZ_W-1:0]       crc_poly_size_in = '0;
  logic [CRC_SIZE-1:0]   crc_init_in = '0;
  logic [CRC_SIZE-1:0]   crc_xorout_in = '0;
  logic                  start = 1'b0;
  logic                  data_valid = 1'b0;
  logic [FRAME_SIZE-1:0] data_in = '0;
  logic                  data_last = 1'b0;
  logic                  data_ready;
  logic                  busy;
  logic                  crc_valid;
  logic [CRC_SIZE-1:0]   crc_out;
  logic [CNT_W-1:0]      beat_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]      msg_q[$];
  longint unsigned m_poly, m_init, m_xor;
  int              m_n;

  crc_stream_engine #(.CRC_SIZE(CRC_SIZE), .FRAME_SIZE(FRAME_SIZE), .CNT_W(CNT_W), .SZ_W(SZ_W)) dut (
    .clk(clk), .rst_n(rst_n), .crc_poly_wr(crc_poly_wr), .crc_poly_in(crc_poly_in),
    .crc_poly_size_in(crc_poly_size_in), .crc_init_in(crc_init_in),
`ifdef CRC_FINAL_XOR_EN
    .crc_xorout_in(crc_xorout_in),
`endif
    .start(start), .data_valid(data_valid), .data_in(data_in), .data_last(data_last),
    .data_ready(data_ready), .busy(busy), .crc_valid(crc_valid), .crc_out(crc_out),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Remainder of (M(x)*x^N + I(x)*x^L) mod G(x) by explicit long division over a bit list
  function automatic longint unsigned ref_crc();
    bit              b[$];
    longint unsigned mask, gen, res;
    int              len;
    mask = (m_n == 64) ? '1 : ((64'd1 << m_n) - 64'd1);
    gen  = (64'd1 << m_n) | (m_poly & mask);
    foreach (msg_q[k]) for (int i = 7; i >= 0; i--) b.push_back(msg_q[k][i]);
    len = b.size();
    for (int i = 0; i < m_n; i++) b.push_back(1'b0);
    for (int i = 0; i < m_n; i++) b[i] ^= bit'(((m_init & mask) >> (m_n - 1 - i)) & 64'd1);
    for (int i = 0; i < len; i++)
      if (b[i]) for (int j = 0; j <= m_n; j++) b[i+j] ^= bit'((gen >> (m_n - j)) & 64'd1);
    res = 0;
    for (int i = 0; i < m_n; i++) res = (res << 1) | longint'(b[len+i]);
`ifdef CRC_FINAL_XOR_EN
    res = res ^ m_xor;
`endif
    return res & mask;
  endfunction

  task automatic cfg(input logic [31:0] poly, input logic [5:0] size, input logic [31:0] init,
                     input logic [31:0] xo);
    crc_poly_wr = 1'b1; crc_poly_in = poly; crc_poly_size_in = size;
    crc_init_in = init; crc_xorout_in = xo;
    m_poly = poly; m_init = init; m_xor = xo;
    m_n = (size == 6'd0 || size > 6'd32) ? 32 : int'(size);
    tick();
    crc_poly_wr = 1'b0;
  endtask

  task automatic load_check_msg();
    msg_q.delete();
    for (int i = 0; i < 9; i++) msg_q.push_back(8'h31 + 8'(i));
  endtask

  // gaps: 0 none, 1 strict alternation, 2 random; wr_at injects a RUN-time config write
  task automatic run_msg(input string tag, input int gaps, input int wr_at, input logic [31:0] exp);
    int i, idle, beat_cyc;
    logic v;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_ready"}, 64'(data_ready), 64'd1);
    chk({tag, "_cnt0"}, 64'(beat_cnt), 64'd0);
    i = 0; idle = 0; beat_cyc = 0; v = 1'b0;
    while (i < msg_q.size()) begin
      if (gaps == 1) v = ~v;
      else if (gaps == 2) v = (idle >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      else v = 1'b1;
      idle = v ? 0 : idle + 1;
      data_valid = v; data_in = msg_q[i]; data_last = (i == msg_q.size() - 1);
      crc_poly_wr = (beat_cyc == wr_at);
      crc_poly_in = 32'h1021; crc_poly_size_in = 6'd16; crc_init_in = 32'hFFFF;
      tick();
      crc_poly_wr = 1'b0;
      beat_cyc++;
      if (v) i++;
      if (i < msg_q.size()) chk({tag, "_novalid_mid"}, 64'(crc_valid), 64'd0);
    end
    data_valid = 1'b0; data_last = 1'b0;
    chk({tag, "_valid"}, 64'(crc_valid), 64'd1);
    chk({tag, "_crc"}, 64'(crc_out), 64'(exp));
    chk({tag, "_cnt"}, 64'(beat_cnt), 64'(msg_q.size()));
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    tick();
    chk({tag, "_valid_pulse"}, 64'(crc_valid), 64'd0);
    chk({tag, "_hold"}, 64'(crc_out), 64'(exp));
  endtask

  initial begin
    logic [31:0] exp32;
    int sizes[8] = '{1, 32, 0, 40, 8, 16, 5, 27};

    #3;
    chk("rst_ready", 64'(data_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(crc_valid), 64'd0);
    chk("rst_crc", 64'(crc_out), 64'd0);
    chk("rst_cnt", 64'(beat_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Beats offered in IDLE are dropped
    data_valid = 1'b1; data_in = 8'hAA;
    tick();
    chk("idle_drop_cnt", 64'(beat_cnt), 64'd0);
    data_valid = 1'b0;

    load_check_msg();
    cfg(32'h07, 6'd8, 32'h0, 32'h0);
    run_msg("crc8", 0, -1, 32'hF4);
    cfg(32'h1021, 6'd16, 32'h0, 32'h0);
    run_msg("xmodem", 0, -1, 32'h31C3);
    run_msg("xmodem_gap", 1, -1, 32'h31C3);
    cfg(32'h04C11DB7, 6'd32, 32'hFFFFFFFF, 32'hFFFFFFFF);
`ifdef CRC_FINAL_XOR_EN
    exp32 = 32'hFC891918;
`else
    exp32 = 32'h0376E6E7;
`endif
    run_msg("mpeg2", 0, -1, exp32);

    // RUN-time config writes are ignored
    cfg(32'h07, 6'd8, 32'h0, 32'h0);
    run_msg("guard", 0, 3, 32'hF4);
    run_msg("guard_next", 0, -1, 32'hF4);

    // Back-to-back start straight out of DONE
    run_msg("b2b_second", 0, -1, 32'hF4);

    // Asynchronous reset mid-message
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_valid = 1'b1; data_in = msg_q[i]; tick();
    end
    data_valid = 1'b0;
    chk("pre_rst_cnt", 64'(beat_cnt), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ready", 64'(data_ready), 64'd0);
    chk("arst_crc", 64'(crc_out), 64'd0);
    chk("arst_cnt", 64'(beat_cnt), 64'd0);
    tick();
    chk("arst_valid", 64'(crc_valid), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("arst_valid2", 64'(crc_valid), 64'd0);
    cfg(32'h07, 6'd8, 32'h0, 32'h0);
    run_msg("after_rst", 0, -1, 32'hF4);

    // Random polynomials, widths (incl. 1, 32 and clamped illegal sizes), init and data
    foreach (sizes[s]) begin
      msg_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) msg_q.push_back(8'($urandom));
      cfg($urandom, 6'(sizes[s]), $urandom, $urandom);
      run_msg($sformatf("rand%0d_n%0d", s, sizes[s]), 2, -1, 32'(ref_crc()));
    end

    // Same-edge config write and start: start must use the new values
    load_check_msg();
    m_poly = 64'h1021; m_init = 64'h0; m_xor = 64'h0; m_n = 16;
    crc_poly_wr = 1'b1; crc_poly_in = 32'h1021; crc_poly_size_in = 6'd16;
    crc_init_in = 32'h0; crc_xorout_in = 32'h0;
    start = 1'b1;
    tick();
    crc_poly_wr = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      data_valid = 1'b1; data_in = msg_q[i]; data_last = (i == 8); tick();
    end
    data_valid = 1'b0; data_last = 1'b0;
    chk("bypass_valid", 64'(crc_valid), 64'd1);
    chk("bypass_crc", 64'(crc_out), 64'(ref_crc()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
